uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Parameters
REQ-001 The block SHALL provide FIFO_DEPTH, default 4, meaning the number of byte entries in the transmit FIFO (power of two, 2..16).
REQ-002 The block SHALL provide PARITY_EN, default 0, meaning 1 inserts an even-parity bit after the data bits.

Interface
REQ-003 The block SHALL have port i_clk, input, 1 bit: system clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port i_tick, input, 1 bit: one-i_clk-cycle baud enable from the upstream frequency divider, one pulse per bit period.
REQ-006 The block SHALL have port i_data, input, 8 bits: byte to enqueue.
REQ-007 The block SHALL have port i_valid, input, 1 bit: i_data is valid this cycle.
REQ-008 The block SHALL have port o_ready, output, 1 bit: FIFO can accept a byte this cycle.
REQ-009 The block SHALL have port o_tx, output, 1 bit: serial line, idle high, registered.
REQ-010 The block SHALL have port o_busy, output, 1 bit: a frame is in progress (state != IDLE).
REQ-011 The block SHALL have port o_level, output, 5 bits: current FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-012 The block SHALL accept a push on each cycle with i_valid=1 and o_ready=1, writing i_data at the write pointer.
REQ-013 The block SHALL drive o_ready = (o_level != FIFO_DEPTH) combinationally from the registered count; a push while full is dropped and changes no state.
REQ-014 The block SHALL wrap the read and write pointers modulo FIFO_DEPTH.
REQ-015 The block SHALL implement the state machine IDLE, START, DATA, PARITY, STOP, with transitions taken only on cycles with i_tick=1.
REQ-016 In IDLE with o_level>0 and i_tick=1, the block SHALL pop the head byte into an 8-bit shift register, enter START, and drive o_tx to 0 at that edge.
REQ-017 From START, on the next tick, the block SHALL enter DATA and drive bit 0 of the byte.
REQ-018 In DATA, the block SHALL send bits 0..7 LSB first, one per tick, using a 3-bit bit counter.
REQ-019 After bit 7, the block SHALL go to PARITY (drive XOR of the 8 data bits) when PARITY_EN=1, else to STOP.
REQ-020 From PARITY, on the next tick, the block SHALL go to STOP.
REQ-021 In STOP, the block SHALL drive o_tx=1 for one tick period.
REQ-022 On the tick ending STOP, the block SHALL pop the next byte and go directly to START (o_tx=0) if o_level>0, else go to IDLE.
REQ-023 Frame length SHALL be 10 tick periods, or 11 with PARITY_EN=1; back-to-back frames SHALL have no idle gap.
REQ-024 A pop SHALL use the count registered before the current edge; a byte pushed on the same cycle as an IDLE tick SHALL NOT be popped until the next tick (no bypass).
REQ-025 On a simultaneous push and pop, o_level SHALL be unchanged; when full, the push SHALL be refused even if a pop occurs that cycle.
REQ-026 i_tick pulses in IDLE with an empty FIFO SHALL have no effect.
REQ-027 i_valid SHALL be accepted independently of i_tick.
REQ-028 o_busy SHALL be 1 in every state except IDLE.

Reset
REQ-029 While i_rst_n=1, the block SHALL immediately, independent of i_clk, force state=IDLE, o_tx=1, o_busy=0, o_level=0, pointers=0, bit counter=0, shift register=0.
REQ-030 A reset asserted mid-frame SHALL abort the frame, return the line high at once, and discard all FIFO contents.
REQ-031 The first push SHALL be accepted on the first rising edge after i_rst_n falls.

Verification
REQ-032 Push 0xA5 with a tick every 16 cycles, PARITY_EN=0 -> o_tx carries 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles; o_busy falls on the tick ending STOP.
REQ-033 PARITY_EN=1, push 0x07 -> the parity bit is 1 and the frame spans 11 tick periods.
REQ-034 Push 5 bytes with no ticks -> o_level=4, o_ready=0, and the 5th byte is dropped; then enable ticks -> 4 back-to-back frames with no high gap between STOP and START.
REQ-035 Push on the same cycle as an IDLE tick -> START begins on the following tick, not the current one.
REQ-036 With o_level=4, pop and push on the same cycle -> push refused and o_level=3.
REQ-037 Assert i_rst_n during DATA bit 3 -> o_tx=1, o_busy=0, o_level=0 within the same cycle, and the next push transmits cleanly.

Source files
------------

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - byte FIFO feeding an 8N1 (optional even parity) serial transmitter
// Frames advance only on i_tick; the FIFO accepts pushes on any cycle.
module uart_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter bit PARITY_EN  = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tick,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy,
    output logic [4:0] o_level
);

    localparam int              PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0]      DEPTH_L = 5'(FIFO_DEPTH);
    localparam logic [PW-1:0]   PTR_ONE = PW'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    level_q, level_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          tx_q, tx_d;
    logic          push, pop;

    assign o_ready = (level_q != DEPTH_L);
    assign push    = i_valid && o_ready;
    // Pops only at frame boundaries, using the pre-edge count (no push bypass).
    assign pop     = i_tick && (level_q != 5'd0) &&
                     ((state_q == ST_IDLE) || (state_q == ST_STOP));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 5'd1;
            2'b01:   level_d = level_q - 5'd1;
            default: level_d = level_q;
        endcase
    end

    // Shift register rotates so its XOR still equals the byte parity after bit 7.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        if (i_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        shift_d = mem_q[rd_ptr_q];
                        state_d = ST_START;
                        tx_d    = 1'b0;
                    end
                end
                ST_START: begin
                    state_d   = ST_DATA;
                    bit_cnt_d = 3'd0;
                    tx_d      = shift_q[0];
                end
                ST_DATA: begin
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = 3'd0;
                        if (PARITY_EN) begin
                            state_d = ST_PARITY;
                            tx_d    = ^shift_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {shift_q[0], shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end
                ST_PARITY: begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
                ST_STOP: begin
                    if (pop) begin
                        shift_d = mem_q[rd_ptr_q];
                        state_d = ST_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst_n) begin
        if (i_rst_n) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= 5'd0;
            shift_q   <= 8'd0;
            bit_cnt_q <= 3'd0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
        end
    end

    assign o_tx    = tx_q;
    assign o_busy  = (state_q != ST_IDLE);
    assign o_level = level_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - checks uart_tx (no parity and even parity) against a frame-list reference model
module tb_uart_tx;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       valid;
    logic [7:0] data;
    logic       ready [2];
    logic       tx    [2];
    logic       busy  [2];
    logic [4:0] level [2];

    int ncmp  = 0;
    int nfail = 0;

    logic [7:0] mfifo [2][DEPTH];
    int         mcnt  [2];
    int         mhead [2];
    logic       fbits [2][11];
    int         fpos  [2];
    int         flen  [2];

    logic [9:0] exp_a5 = 10'b1101001010;

    always #5 clk = ~clk;

    uart_tx #(.FIFO_DEPTH(DEPTH), .PARITY_EN(1'b0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst), .i_tick(tick), .i_data(data), .i_valid(valid),
        .o_ready(ready[0]), .o_tx(tx[0]), .o_busy(busy[0]), .o_level(level[0])
    );

    uart_tx #(.FIFO_DEPTH(DEPTH), .PARITY_EN(1'b1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst), .i_tick(tick), .i_data(data), .i_valid(valid),
        .o_ready(ready[1]), .o_tx(tx[1]), .o_busy(busy[1]), .o_level(level[1])
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            mcnt[k]  = 0;
            mhead[k] = 0;
            fpos[k]  = 0;
            flen[k]  = 0;
        end
    endtask

    // One rising edge: frame bit list advances on ticks, FIFO push uses pre-edge fullness.
    task automatic model_edge(input bit v, input logic [7:0] d, input bit t);
        for (int k = 0; k < 2; k++) begin
            bit rdy;
            logic [7:0] b;
            rdy = (mcnt[k] < DEPTH);
            if (t) begin
                if (flen[k] > 0) begin
                    fpos[k]++;
                    if (fpos[k] == flen[k]) flen[k] = 0;
                end
                if (flen[k] == 0 && mcnt[k] > 0) begin
                    b        = mfifo[k][mhead[k]];
                    mhead[k] = (mhead[k] + 1) % DEPTH;
                    mcnt[k]--;
                    fbits[k][0] = 1'b0;
                    for (int i = 0; i < 8; i++) fbits[k][1 + i] = b[i];
                    if (k == 1) begin
                        fbits[k][9]  = ^b;
                        fbits[k][10] = 1'b1;
                        flen[k]      = 11;
                    end else begin
                        fbits[k][9] = 1'b1;
                        flen[k]     = 10;
                    end
                    fpos[k] = 0;
                end
            end
            if (v && rdy) begin
                mfifo[k][(mhead[k] + mcnt[k]) % DEPTH] = d;
                mcnt[k]++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 2; k++) begin
            logic etx;
            etx = (flen[k] > 0) ? fbits[k][fpos[k]] : 1'b1;
            chk($sformatf("%s_tx%0d", tag, k),    {7'd0, tx[k]},    {7'd0, etx});
            chk($sformatf("%s_busy%0d", tag, k),  {7'd0, busy[k]},  {7'd0, (flen[k] > 0)});
            chk($sformatf("%s_level%0d", tag, k), {3'd0, level[k]}, 8'(mcnt[k]));
            chk($sformatf("%s_ready%0d", tag, k), {7'd0, ready[k]}, {7'd0, (mcnt[k] < DEPTH)});
        end
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit t, input string tag);
        valid = v;
        data  = d;
        tick  = t;
        @(posedge clk);
        model_edge(v, d, t);
        @(negedge clk);
        check_all(tag);
        valid = 1'b0;
        tick  = 1'b0;
    endtask

    task automatic run_ticks(input int n, input int per, input string tag);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 8'd0, (i % per) == (per - 1), tag);
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_clear();
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        tick  = 1'b0;
        valid = 1'b0;
        data  = 8'd0;
        model_clear();
        #1;
        check_all("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // First push lands on the first edge after reset release.
        step(1'b1, 8'hA5, 1'b0, "first_push");
        chk("first_push_level", {3'd0, level[0]}, 8'd1);

        // 0xA5, tick every 16 cycles.
        for (int b = 0; b < 11; b++) begin
            step(1'b0, 8'd0, 1'b1, "a5");
            if (b < 10) chk($sformatf("a5_bit%0d", b), {7'd0, tx[0]}, {7'd0, exp_a5[b]});
            else        chk("a5_busy_fall", {7'd0, busy[0]}, 8'd0);
            for (int c = 0; c < 15; c++) step(1'b0, 8'd0, 1'b0, "a5_hold");
        end
        run_ticks(16, 16, "a5_drain");

        // Parity frame for 0x07 spans 11 ticks with parity bit 1.
        step(1'b1, 8'h07, 1'b0, "par_push");
        for (int b = 0; b < 12; b++) begin
            step(1'b0, 8'd0, 1'b1, "par");
            if (b == 9)  chk("par_bit", {7'd0, tx[1]}, 8'd1);
            if (b == 10) chk("par_busy_stop", {7'd0, busy[1]}, 8'd1);
            if (b == 11) chk("par_busy_fall", {7'd0, busy[1]}, 8'd0);
            for (int c = 0; c < 3; c++) step(1'b0, 8'd0, 1'b0, "par_hold");
        end

        // Overfill with no ticks, then back-to-back frames.
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, "fill");
        chk("fill_level", {3'd0, level[0]}, 8'd4);
        chk("fill_ready", {7'd0, ready[0]}, 8'd0);
        run_ticks(100, 2, "b2b");

        // Push on the same cycle as an idle tick: no bypass.
        step(1'b1, 8'h3C, 1'b1, "nobypass");
        chk("nobypass_tx", {7'd0, tx[0]}, 8'd1);
        chk("nobypass_busy", {7'd0, busy[0]}, 8'd0);
        step(1'b0, 8'd0, 1'b1, "nobypass_start");
        chk("nobypass_start_tx", {7'd0, tx[0]}, 8'd0);
        run_ticks(36, 3, "nobypass_drain");

        // Full FIFO: simultaneous pop and push refuses the push.
        for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0, "full");
        step(1'b1, 8'hEE, 1'b1, "full_poppush");
        chk("full_poppush_level", {3'd0, level[0]}, 8'd3);
        run_ticks(100, 2, "full_drain");

        // Reset during data bit 3.
        step(1'b1, 8'h96, 1'b0, "mid_push");
        step(1'b1, 8'h5A, 1'b0, "mid_push");
        for (int i = 0; i < 5; i++) step(1'b0, 8'd0, 1'b1, "mid_run");
        do_reset("mid_reset");
        chk("mid_reset_level", {3'd0, level[0]}, 8'd0);
        step(1'b1, 8'($urandom), 1'b0, "post_reset_push");
        run_ticks(30, 2, "post_reset_frame");

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            step(($urandom % 10) < 3, 8'($urandom), ($urandom % 3) == 0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
